// File: rtl/pooled_stream_packer.sv
// Packs 8-bit pooled values four to a 32-bit word and streams them through a
// first-word-fall-through FIFO onto an AXI4-Stream master, flagging frame ends.
module pooled_stream_packer #(
    parameter int M          = 26,
    parameter int P          = 2,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          external_reset,
    input  logic          pool_valid,
    input  logic [DW-1:0] pool_data,
    output logic [31:0]   m_axis_tdata,
    output logic [3:0]    m_axis_tkeep,
    output logic          m_axis_tlast,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          stall_req,
    output logic          overflow,
    output logic          frame_done
);

    localparam int Q    = M / P;
    localparam int NVAL = Q * Q;
    localparam int VCW  = (NVAL > 1) ? $clog2(NVAL) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int EW   = 37;

    logic [1:0]     lane_q, lane_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic [31:0]    asm_q, asm_d;
    logic [3:0]     keep_q, keep_d;

    logic           push;
    logic [31:0]    push_word;
    logic [3:0]     push_keep;
    logic           push_last;

    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           frame_done_q, frame_done_d;

    logic           empty, full, pop, wr_en;
    logic [EW-1:0]  head;

    always_comb begin
        lane_d    = lane_q;
        vcnt_d    = vcnt_q;
        asm_d     = asm_q;
        keep_d    = keep_q;
        push      = 1'b0;
        push_word = asm_q;
        push_keep = keep_q;
        push_last = 1'b0;
        if (pool_valid) begin
            push_word = asm_q | (32'(pool_data) << {lane_q, 3'b000});
            push_keep = keep_q | (4'b0001 << lane_q);
            push_last = (vcnt_q == VCW'(NVAL - 1));
            vcnt_d    = push_last ? '0 : vcnt_q + 1'b1;
            // A frame's final value closes the word early so frames never share a word.
            if (lane_q == 2'd3 || push_last) begin
                push   = 1'b1;
                asm_d  = '0;
                keep_d = '0;
                lane_d = '0;
            end else begin
                asm_d  = push_word;
                keep_d = push_keep;
                lane_d = lane_q + 2'd1;
            end
        end
    end

    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == CW'(FIFO_DEPTH));
        head         = mem_q[rd_ptr_q];
        pop          = !empty && m_axis_tready;
        wr_en        = push && (!full || pop);
        wr_ptr_d     = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
        overflow_d   = overflow_q | (push && full && !pop);
        frame_done_d = pop && head[36];
    end

    always_ff @(posedge clk) begin
        if (external_reset) begin
            lane_q       <= '0;
            vcnt_q       <= '0;
            asm_q        <= '0;
            keep_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            vcnt_q       <= vcnt_d;
            asm_q        <= asm_d;
            keep_q       <= keep_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!external_reset && wr_en) begin
            mem_q[wr_ptr_q] <= {push_last, push_keep, push_word};
        end
    end

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 : head[31:0];
    assign m_axis_tkeep  = empty ? '0 : head[35:32];
    assign m_axis_tlast  = empty ? 1'b0 : head[36];
    assign stall_req     = (count_q >= CW'(FIFO_DEPTH - 2));
    assign overflow      = overflow_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_pooled_stream_packer.sv
// Scoreboard bench: a value-list reference model predicts the word stream and
// FIFO occupancy; a negedge monitor compares every cycle's outputs against it.
module tb_pooled_stream_packer;

    localparam int NVAL  = 169;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        external_reset = 1'b1;
    logic        pool_valid = 1'b0;
    logic [7:0]  pool_data = '0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        stall_req;
    logic        overflow;
    logic        frame_done;

    pooled_stream_packer #(.M(26), .P(2), .DW(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .external_reset(external_reset),
        .pool_valid    (pool_valid),
        .pool_data     (pool_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .stall_req     (stall_req),
        .overflow      (overflow),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] cur_vals[$];
    int         vidx    = 0;
    logic       exp_ovf = 1'b0;
    logic       exp_fd  = 1'b0;
    bit         armed   = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int beats  = 0;
    int fd_cnt = 0;
    int lasts  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        beat_t b;
        bit    pop;
        if (armed) begin
            chk("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("tdata", m_axis_tdata, exp_q[0].d);
                chk("tkeep", 32'(m_axis_tkeep), 32'(exp_q[0].k));
                chk("tlast", 32'(m_axis_tlast), 32'(exp_q[0].l));
            end else begin
                chk("idle_outputs", {m_axis_tdata[27:0], m_axis_tkeep} | 32'(m_axis_tlast), 32'd0);
            end
            chk("stall_req", 32'(stall_req), 32'(exp_q.size() >= DEPTH - 2));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                if (m_axis_tlast) lasts++;
            end
            if (frame_done) fd_cnt++;
        end
        // Advance the reference model by the effect of the coming rising edge.
        if (external_reset) begin
            exp_q.delete();
            cur_vals.delete();
            vidx    = 0;
            exp_ovf = 1'b0;
            exp_fd  = 1'b0;
        end else begin
            pop    = (exp_q.size() != 0) && m_axis_tready;
            exp_fd = pop && exp_q[0].l;
            if (pop) void'(exp_q.pop_front());
            if (pool_valid) begin
                cur_vals.push_back(pool_data);
                vidx++;
                if (cur_vals.size() == 4 || vidx == NVAL) begin
                    b.d = '0;
                    for (int i = 0; i < cur_vals.size(); i++) b.d = b.d | (32'(cur_vals[i]) << (8 * i));
                    b.k = 4'((1 << cur_vals.size()) - 1);
                    b.l = (vidx == NVAL);
                    if (vidx == NVAL) vidx = 0;
                    cur_vals.delete();
                    if (exp_q.size() < DEPTH) exp_q.push_back(b);
                    else exp_ovf = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        pool_valid     = 1'b0;
        external_reset = 1'b1;
        step();
        step();
        armed          = 1'b1;
        external_reset = 1'b0;
    endtask

    task automatic feed(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            pool_valid = 1'b1;
            pool_data  = 8'(first + i);
            step();
        end
        pool_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pool_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int b0, f0, l0;
        step();
        do_reset();

        // One full frame with the sink always ready.
        m_axis_tready = 1'b1;
        b0 = beats; f0 = fd_cnt;
        feed(NVAL, 1);
        idle(10);
        chk("frame_beats", 32'(beats - b0), 32'd43);
        chk("frame_done_count", 32'(fd_cnt - f0), 32'd1);

        // Back-pressure into stall region, then drain.
        do_reset();
        m_axis_tready = 1'b0;
        feed(56, 1);
        idle(4);
        m_axis_tready = 1'b1;
        idle(20);

        // Seventeen words into a stalled FIFO: last one dropped.
        do_reset();
        m_axis_tready = 1'b0;
        feed(68, 1);
        idle(3);
        m_axis_tready = 1'b1;
        idle(20);

        // Push into a full FIFO during the first pop.
        do_reset();
        m_axis_tready = 1'b0;
        feed(67, 1);
        m_axis_tready = 1'b1;
        feed(1, 68);
        idle(20);

        // Reset mid-frame, colliding with a value and a pop.
        do_reset();
        m_axis_tready = 1'b1;
        feed(10, 1);
        pool_valid     = 1'b1;
        pool_data      = 8'hEE;
        external_reset = 1'b1;
        step();
        external_reset = 1'b0;
        pool_valid     = 1'b0;
        chk("tvalid_after_reset", 32'(m_axis_tvalid), 32'd0);
        feed(1, 8'h55);
        feed(3, 1);
        idle(4);

        // Two consecutive frames.
        do_reset();
        m_axis_tready = 1'b1;
        l0 = lasts; b0 = beats;
        feed(NVAL, 1);
        feed(NVAL, 1);
        idle(10);
        chk("two_frame_beats", 32'(beats - b0), 32'd86);
        chk("two_frame_lasts", 32'(lasts - l0), 32'd2);

        // Random traffic, light then heavy back-pressure.
        do_reset();
        for (int c = 0; c < 700; c++) begin
            pool_valid    = ($urandom_range(9) < 7);
            pool_data     = 8'($urandom);
            m_axis_tready = $urandom_range(1);
            step();
        end
        do_reset();
        for (int c = 0; c < 700; c++) begin
            pool_valid    = ($urandom_range(9) < 7);
            pool_data     = 8'($urandom);
            m_axis_tready = ($urandom_range(9) == 0);
            step();
        end
        m_axis_tready = 1'b1;
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
